// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types and constants for the instruction-fetch queue.
//   HALT_WORD   - instruction encoding that stops fetch until a redirect
//   fq_entry_t  - queue entry {instr, pc, pc4} at the default 32-bit widths
package fetch_queue_pkg;

  localparam int FQ_WORD_W = 32;
  localparam int FQ_PC_W   = 32;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [FQ_WORD_W-1:0] instr;
    logic [FQ_PC_W-1:0]   pc;
    logic [FQ_PC_W-1:0]   pc4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: icache port, redirect and decode handshake of the fetch queue.
//   master - the fetch queue (drives imemREN/imemaddr, deq_*, count, halted)
//   slave  - the environment (icache, branch resolution, decode latch)
interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  parameter int PC_W   = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              imemREN;
  logic [PC_W-1:0]   imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              deq_ready;
  logic              deq_valid;
  logic [WORD_W-1:0] deq_instr;
  logic [PC_W-1:0]   deq_pc;
  logic [PC_W-1:0]   deq_pc4;
  logic [CW-1:0]     count;
  logic              halted;

  modport master (
    output imemREN, imemaddr, deq_valid, deq_instr, deq_pc, deq_pc4, count, halted,
    input  ihit, imemload, redirect, redirect_pc, deq_ready
  );

  modport slave (
    input  imemREN, imemaddr, deq_valid, deq_instr, deq_pc, deq_pc4, count, halted,
    output ihit, imemload, redirect, redirect_pc, deq_ready
  );
endinterface

// File: rtl/fetch_queue_storage.sv
// fq_storage: DEPTH-entry register array for the fetch queue.
//   CLK, nRST      - clock, async active-low reset (entries cleared to 0)
//   we/waddr/wdata - single write port
//   raddr/rdata    - combinational read port
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 96,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch buffer between the icache port and decode.
// Owns the fetch PC, requests whenever a slot is free, buffers up to DEPTH
// {instr, pc, pc4} entries and hands them to decode via valid/ready.
// A redirect flushes everything and restarts fetch; a HALT word stops fetch.
//   CLK, nRST - clock, async active-low reset
//   bus       - fetch_queue_if.master (icache, redirect, decode, status)
// Optional build macro FETCHQ_BYPASS_EN: an empty queue forwards the word
// being pushed straight to deq_* in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH   = 4,
  parameter int              WORD_W  = 32,
  parameter int              PC_W    = 32,
  parameter logic [PC_W-1:0] PC_INIT = '0
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc4;
  } entry_t;

  logic [PC_W-1:0] fetch_pc;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            halted_q;
  logic            empty, full, push, pop, wr_en, is_halt;
  entry_t          wr_entry, rd_entry, head;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign is_halt  = (bus.imemload == WORD_W'(HALT_WORD));
  assign wr_entry = '{instr: bus.imemload, pc: fetch_pc, pc4: fetch_pc + PC_W'(4)};

  // Request depends on registered state only; a same-cycle pop does not
  // reopen a full queue.
  assign bus.imemREN  = !halted_q && !full;
  assign bus.imemaddr = fetch_pc;
  assign push         = bus.imemREN && bus.ihit && !bus.redirect;

`ifdef FETCHQ_BYPASS_EN
  logic bypass;
  assign bypass        = empty && push;
  assign bus.deq_valid = !empty || bypass;
  assign head          = bypass ? wr_entry : rd_entry;
  assign pop           = !empty && bus.deq_ready && !bus.redirect;
  // A bypassed word taken by decode in the same cycle is never stored.
  assign wr_en         = push && !(bypass && bus.deq_ready);
`else
  assign bus.deq_valid = !empty;
  assign head          = rd_entry;
  assign pop           = !empty && bus.deq_ready && !bus.redirect;
  assign wr_en         = push;
`endif

  assign bus.deq_instr = head.instr;
  assign bus.deq_pc    = head.pc;
  assign bus.deq_pc4   = head.pc4;
  assign bus.count     = cnt;
  assign bus.halted    = halted_q;

  fq_storage #(.DEPTH(DEPTH), .W($bits(entry_t))) u_storage (
    .CLK   (CLK),
    .nRST  (nRST),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc <= PC_INIT;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      halted_q <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      halted_q <= 1'b0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + PC_W'(4);
        if (is_halt) halted_q <= 1'b1;
      end
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch buffer that sits between the program counter / icache port and the fetch-decode pipeline latch.
- It owns the fetch PC and issues imem requests whenever space is free. It buffers up to DEPTH fetched words with their PC and PC+4 and presents them to decode through a valid/ready handshake.
- Redirects from branch/jump resolution flush it. It stops fetching after a HALT word until redirected.

Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2
- WORD_W, 32, instruction width
- PC_W, 32, PC width
- PC_INIT, 0, fetch PC after reset

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- imemREN  out  1  icache read request
- imemaddr  out  PC_W  icache address; equals the fetch PC
- ihit  in  1  icache returns imemload for imemaddr this cycle
- imemload  in  WORD_W  fetched instruction
- redirect  in  1  flush and restart fetch
- redirect_pc  in  PC_W  new fetch PC
- deq_ready  in  1  decode accepts the head entry this cycle
- deq_valid  out  1  head entry valid
- deq_instr  out  WORD_W  head instruction
- deq_pc  out  PC_W  head PC
- deq_pc4  out  PC_W  head PC+4
- count  out  $clog2(DEPTH)+1  occupancy
- halted  out  1  HALT word captured; fetch stopped

Behaviour:
- Reset (async, nRST=0):
  - fetch PC = PC_INIT; count = 0; rd/wr pointers = 0; halted = 0.
  - deq_valid = 0; imemREN = 1 after release.
  - deq_instr/deq_pc/deq_pc4 are don't-care while deq_valid = 0 and are driven to 0 in reset.
- imemREN = !halted && (count < DEPTH); imemaddr = fetch PC. This output is combinational from registers only.
- Push when imemREN && ihit && !redirect:
  - Write {imemload, fetch PC, fetch PC+4} at wr_ptr.
  - wr_ptr++ with modulo-DEPTH wrap; fetch PC += 4. PC arithmetic wraps mod 2^PC_W.
- HALT word: if a pushed imemload equals HALT_WORD (0xFFFFFFFF), the entry is still enqueued and halted <= 1 next cycle. imemREN then drops; fetch PC holds at HALT address + 4.
- Pop when deq_valid && deq_ready && !redirect: rd_ptr++ with wrap.
- Simultaneous push and pop: count is unchanged; both take effect.
- Full: no request is issued, even if a pop occurs in the same cycle. A request issues the following cycle.
- Empty: deq_valid = 0; deq_ready is ignored.
- Redirect has priority over everything. Next cycle:
  - count = 0, pointers = 0, halted = 0, fetch PC = redirect_pc.
  - An ihit or pop in the redirect cycle is discarded.
  - The queue refills from redirect_pc.
- imemaddr is stable while imemREN=1 and ihit=0, which holds for multi-cycle icache misses.
- Latency (macro off): an ihit in cycle N gives deq_valid in cycle N+1. Sustained throughput is 1 word/cycle on hits.

Optional Feature:
- FETCHQ_BYPASS_EN defined: when count==0 and a push occurs, the word is also presented on deq_* in the same cycle (deq_valid=1).
  - If deq_ready is also 1, the word is consumed and not stored; count stays 0.
  - Redirect still suppresses the bypass.
- FETCHQ_BYPASS_EN undefined: no combinational path from imemload/ihit to deq_*; minimum latency is 1 cycle.

Decomposition:
- Existing cpu_types_pkg:
  - HALT_WORD constant.
  - fq_entry_t packed struct {instr, pc, pc4}, parametrised via WORD_W/PC_W defaults matching word_t.
- One sub-module, fq_storage: DEPTH-entry register array, with one write port and a combinational read port at rd_ptr.
- Pointer/count/PC control stays in fetch_queue.

Test Plan:
- Reset, then ihit=1 every cycle with imemload = 0x20010000 + n and deq_ready=1 → imemaddr 0,4,8,…
  - Macro off: deq_pc 0,4,8… starting one cycle after the first ihit.
  - Macro on: deq_pc appears in the same cycle as the first ihit; count stays 0.
- deq_ready=0, ihit=1 continuously → count climbs 1..4 then holds at 4; imemREN=0 at 4; imemaddr holds at 0x10.
  - Then pulse deq_ready for one cycle → count=3, then 4 again; imemaddr advances to 0x14.
- Queue at count=2; assert redirect with redirect_pc=0x100 and ihit=1 in the same cycle → next cycle count=0, deq_valid=0, imemaddr=0x100; the ihit word is absent from later output.
- imemload=0xFFFFFFFF at PC 0x8 → entry at 0x8 is dequeued with deq_pc4=0xC; halted=1; imemREN=0 indefinitely.
  - Then redirect to 0x40 → halted=0 and fetch resumes at 0x40.
- ihit held low 5 cycles at PC 0x20 → imemREN=1 and imemaddr=0x20 stable throughout; a single push occurs on the ihit cycle.
- Apply nRST=0 asynchronously mid-fill (count=3) → outputs reset immediately without waiting for a clock edge; count=0; imemaddr=PC_INIT after release.
